// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if: groups the byte-stream handshake, the instruction-memory
// write port and the status outputs of imem_loader.
//   master : stream source / supervisor (drives start, in_valid, in_data)
//   slave  : the loader itself
// Signals:
//   start     one-cycle pulse that begins a load session
//   in_valid  in_data holds a valid byte
//   in_data   stream byte (big-endian frame)
//   in_ready  loader accepts a byte this cycle
//   mem_we    instruction-memory write strobe, one cycle per word
//   mem_addr  word address of the write
//   mem_wdata 16-bit instruction word
//   cpu_hold  1 = pipeline must not fetch/advance
//   done      image loaded (level)
//   err       session aborted (level)
// ---------------------------------------------------------------------------
interface imem_loader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader: writer side of the instruction memory read by Fetch.
// Accepts a valid/ready byte stream framed as LEN_HI, LEN_LO (word count N)
// followed by N x {W_HI, W_LO}, and writes each 16-bit word to consecutive
// word addresses starting at 0. cpu_hold freezes the pipeline until done.
// Ports:
//   clk   rising-edge clock shared with the pipeline
//   rst   asynchronous, active-high reset
//   bus   imem_loader_if.slave (stream in, memory write port, status)
// Parameters:
//   ADDR_W  word-address width; capacity is 2**ADDR_W words
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  adds a trailing XOR checksum byte (CHK state)
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input logic          clk,
   input logic          rst,
   imem_loader_if.slave bus
);
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned CAP   = 1 << ADDR_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DAT_HI,
      ST_DAT_LO,
      ST_CHK,
      ST_DONE,
      ST_ERR
   } state_t;

   // State entered once the frame payload has been fully accepted
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t ST_FRAME_END = ST_CHK;
`else
   localparam state_t ST_FRAME_END = ST_DONE;
`endif

   state_t            r_state;
   state_t            w_next;
   logic              r_in_ready;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [15:0]       r_mem_wdata;
   logic              r_cpu_hold;
   logic              r_done;
   logic              r_err;
   logic [7:0]        r_len_hi;
   logic [7:0]        r_dat_hi;
   logic [CNT_W-1:0]  r_len;
   logic [CNT_W-1:0]  r_word_cnt;

   logic [7:0]        w_len_hi;
   logic [7:0]        w_dat_hi;
   logic [CNT_W-1:0]  w_len;
   logic [CNT_W-1:0]  w_word_cnt;
   logic              w_write;
   logic              w_accept;
   logic [15:0]       w_full_len;
   logic [CNT_W-1:0]  w_cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        r_csum;
   logic [7:0]        w_csum;
`endif

   // in_ready mirrors the accepting states, so this is the handshake itself
   assign w_accept   = bus.in_valid & r_in_ready;
   assign w_full_len = {r_len_hi, bus.in_data};
   assign w_cnt_inc  = CNT_W'(r_word_cnt + CNT_W'(1));

   // Next-state and datapath updates
   always_comb begin
      w_next     = r_state;
      w_len_hi   = r_len_hi;
      w_dat_hi   = r_dat_hi;
      w_len      = r_len;
      w_word_cnt = r_word_cnt;
      w_write    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      w_csum     = r_csum;
`endif
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (bus.start) begin
               w_next     = ST_LEN_HI;
               w_word_cnt = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               w_csum     = '0;
`endif
            end
         end
         ST_LEN_HI: begin
            if (w_accept) begin
               w_len_hi = bus.in_data;
               w_next   = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (w_accept) begin
               if (w_full_len == 16'd0) begin
                  w_next = ST_FRAME_END;
               end else if (32'(w_full_len) > CAP) begin
                  w_next = ST_ERR;
               end else begin
                  w_len  = CNT_W'(w_full_len);
                  w_next = ST_DAT_HI;
               end
            end
         end
         ST_DAT_HI: begin
            if (w_accept) begin
               w_dat_hi = bus.in_data;
               w_next   = ST_DAT_LO;
            end
         end
         ST_DAT_LO: begin
            if (w_accept) begin
               w_write    = 1'b1;
               w_word_cnt = w_cnt_inc;
               w_next     = (w_cnt_inc == r_len) ? ST_FRAME_END : ST_DAT_HI;
            end
         end
         ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_accept) begin
               w_next = (bus.in_data == r_csum) ? ST_DONE : ST_ERR;
            end
`else
            w_next = ST_IDLE;
`endif
         end
         default: w_next = ST_IDLE;
      endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
      // Running XOR over every frame byte; the checksum byte itself is excluded
      if (w_accept && (r_state != ST_CHK)) begin
         w_csum = r_csum ^ bus.in_data;
      end
`endif
   end

   // State and registered outputs, all derived from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_hold  <= 1'b1;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_len_hi    <= '0;
         r_dat_hi    <= '0;
         r_len       <= '0;
         r_word_cnt  <= '0;
      end else begin
         r_state     <= w_next;
         r_in_ready  <= (w_next == ST_LEN_HI) || (w_next == ST_LEN_LO) ||
                        (w_next == ST_DAT_HI) || (w_next == ST_DAT_LO) ||
                        (w_next == ST_CHK);
         r_cpu_hold  <= (w_next != ST_DONE);
         r_done      <= (w_next == ST_DONE);
         r_err       <= (w_next == ST_ERR);
         r_mem_we    <= w_write;
         r_len_hi    <= w_len_hi;
         r_dat_hi    <= w_dat_hi;
         r_len       <= w_len;
         r_word_cnt  <= w_word_cnt;
         if (w_write) begin
            r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
            r_mem_wdata <= {r_dat_hi, bus.in_data};
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Checksum accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_csum <= '0;
      end else begin
         r_csum <= w_csum;
      end
   end
`endif

   assign bus.in_ready  = r_in_ready;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.cpu_hold  = r_cpu_hold;
   assign bus.done      = r_done;
   assign bus.err       = r_err;
endmodule
